rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Two-port arbiter that shares the single-port 8K x 32 instruction/constant ROM between the instruction-fetch unit (port 0) and the data-side constant loader (port 1). Grants one read per cycle, drives the ROM address, tracks in-flight reads through the ROM's fixed read latency, and routes each returned word to the requester that issued it. It sits between the two requesters and the `rom` wrapper; the ROM itself is unchanged.

## Interface
Parameters:
- `ROM_LAT`, default 1: ROM read latency in cycles, from address to `doa`. Legal values are 1 and 2.
- `ADDR_W`, default 13: word-address width.
- `DATA_W`, default 32: data width.

Ports:
- `clka` in, 1: single clock for the block and the ROM.
- `rsta` in, 1: synchronous, active-high reset.
- `req0` / `req1` in, 1: read request from port 0 / port 1.
- `addr0` / `addr1` in, ADDR_W: word address for port 0 / port 1.
- `gnt0` / `gnt1` out, 1: request accepted this cycle (combinational).
- `rvalid0` / `rvalid1` out, 1: read data valid for port 0 / port 1.
- `rdata0` / `rdata1` out, DATA_W: read data for port 0 / port 1.
- `rom_addra` out, ADDR_W: address to the ROM.
- `rom_doa` in, DATA_W: data from the ROM.

## Operation
- Requester handshake:
  - A requester holds `reqN` and `addrN` stable until it sees `gntN`=1 in the same cycle.
  - The transfer occurs on the rising edge where `reqN && gntN`.
  - The requester may drop `reqN` or issue a new address the next cycle.
- Arbitration:
  - At most one grant per cycle.
  - `gnt0 | gnt1` = `req0 | req1`: no idle cycle while any request is pending.
  - Only one requester: it is granted.
  - Both requesting: round-robin. The port not granted most recently wins.
  - Round-robin pointer `last` (1 bit) updates on every grant. Its reset value is 1, so port 0 wins the first conflict.
- Address path:
  - `rom_addra` = address of the granted port.
  - With no grant, `rom_addra` holds its previous value (registered hold mux), so the ROM is not toggled needlessly.
- Response tracking:
  - A ROM_LAT-deep shift register of {valid, port_id} entries.
  - A grant pushes {1, granted port}. No grant pushes {0, x}.
  - When the tail entry is valid, `rom_doa` is steered to `rdataN` of that entry's port and `rvalidN` pulses for one cycle.
  - Responses are in order per port and globally.
  - Responses have no backpressure; requesters must accept `rvalidN` whenever it occurs.
- Data for the non-selected port: `rdataN` is don't-care when `rvalidN`=0. The implementation drives both `rdata0` and `rdata1` = `rom_doa`.

## Timing
- Grant latency: 0 cycles (combinational from `reqN` and `last`).
- Read latency: `rvalidN` asserts exactly ROM_LAT cycles after the grant edge.
  - ROM_LAT=1: grant at edge k, `rvalidN`=1 during cycle k+1.
- Throughput: one read per cycle aggregate. Under continuous dual requests each port gets one read every 2 cycles.
- Reset values (`rsta`=1 at an edge):
  - `rvalid0`=`rvalid1`=0.
  - All pipe valid bits = 0.
  - `last`=1.
  - `rom_addra`=0.
- `gnt0`/`gnt1` are forced to 0 while `rsta`=1.
- Reset mid-operation: in-flight reads are dropped with no `rvalid`. Requesters re-issue after reset.
- Simultaneous grant and return in the same cycle are independent; the pipe shifts every cycle.
- Address wrap: none. Full 13-bit range is legal. Address 0x1FFF is valid.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, port 0 always wins a conflict, and `last` is not implemented. Port 1 may starve; this is intended for fetch-critical builds.
  - Undefined (default): round-robin as described above.

## Structure
- Package `rom_arb_pkg`:
  - `ROM_ADDR_W`=13 and `ROM_DATA_W`=32.
  - typedef `rom_port_t` (1-bit port id).
  - typedef `rom_tag_t` struct {valid, port}.
- Sub-module `rom_arb_pipe`: the ROM_LAT-deep `rom_tag_t` shift register, with synchronous reset and a tail output.
- The top level holds the arbiter, the address hold register, and response steering.

## Test plan
- Reset, then single read: `req0`=1, `addr0`=0x0010 → `gnt0`=1 same cycle, `rom_addra`=0x0010, `rvalid0`=1 after ROM_LAT cycles with `rdata0`=ROM[0x0010], `rvalid1`=0 throughout.
- Conflict: after reset, `req0`/`req1` both held with addr0=0x0001, addr1=0x1FFF → grants alternate 0,1,0,1. `rvalid` pulses alternate by port with the correct words, one per cycle.
- Back-to-back single port: `req1` held for 4 cycles with addresses 0x0100..0x0103 → 4 consecutive grants and 4 consecutive `rvalid1` pulses in order.
- Reset mid-flight: grant at edge k, `rsta`=1 at edge k+1 (ROM_LAT=2) → no `rvalid` pulse, `rom_addra`=0, and the next conflict grants port 0.
- Idle hold: request 0x0AAA, then no requests for 5 cycles → `rom_addra` stays 0x0AAA and no `rvalid` pulses.
- `ROM_ARB_FIXED_PRIO_EN` build: both ports requesting for 6 cycles → `gnt0`=1 every cycle and `gnt1`=0.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

    localparam int ROM_ADDR_W = 13;
    localparam int ROM_DATA_W = 32;

    // Requester identifier: port 0 = instruction fetch, port 1 = constant loader.
    typedef logic rom_port_t;

    localparam rom_port_t PORT0 = 1'b0;
    localparam rom_port_t PORT1 = 1'b1;

    // One in-flight read: whether a read was issued in that slot, and for whom.
    typedef struct packed {
        logic      valid;
        rom_port_t port;
    } rom_tag_t;

    localparam rom_tag_t TAG_IDLE = '{valid: 1'b0, port: PORT0};

endpackage

// File: rtl/rom_arb_pipe.sv
// Response-tracking shift register: one rom_tag_t per cycle of ROM latency.
// The tail entry describes the word currently presented on the ROM data bus.
module rom_arb_pipe
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clka,
    input  logic     rsta,
    input  rom_tag_t push,
    output rom_tag_t tail
);

    rom_tag_t stage_q [DEPTH];
    rom_tag_t stage_d [DEPTH];

    // Next state: new tag enters at stage 0, everything else moves one stage on.
    always_comb begin
        stage_d[0] = push;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift every cycle; reset empties the pipe so in-flight reads are dropped.
    always_ff @(posedge clka) begin
        if (rsta) begin
            // NOTE: the tracking stages are control state (valid bits), so every
            // stage is reset; a data-only memory would not need this.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            // NOTE: non-blocking assignment lets all stages shift on the same edge
            // without one stage seeing another's freshly written value.
            stage_q <= stage_d;
        end
    end

    assign tail = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of the single-port instruction/constant ROM.
// Grants at most one read per cycle, holds the ROM address between grants,
// and steers each returned word to the port that issued it.
// Build option: define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always
// wins a conflict); otherwise conflicts are resolved round-robin.
// ROM_LAT is the ROM read latency counted from the grant edge (legal: 1 or 2);
// the registered rom_addra is the first cycle of that latency.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ROM_LAT = 1,
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = ROM_DATA_W
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addra,
    input  logic [DATA_W-1:0] rom_doa
);

    logic [ADDR_W-1:0] rom_addra_q;
    logic [ADDR_W-1:0] rom_addra_d;
    rom_tag_t          push_tag;
    rom_tag_t          tail_tag;

`ifdef ROM_ARB_FIXED_PRIO_EN

    // Fixed priority: port 0 wins every conflict; no grants while in reset.
    always_comb begin
        // NOTE: both outputs get a default before any branch, so no path
        // leaves them unassigned and no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rsta) begin
            if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

`else

    // Port granted most recently; resets to port 1 so port 0 wins the first conflict.
    rom_port_t last_q;
    rom_port_t last_d;

    // Round-robin: a lone requester is always granted; on conflict the port
    // that was not granted most recently wins. No grants while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rsta) begin
            if (req0 && req1) begin
                gnt0 = (last_q == PORT1);
                gnt1 = (last_q == PORT0);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Pointer follows every grant, conflicting or not.
    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = PORT0;
        end else if (gnt1) begin
            last_d = PORT1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clka) begin
        if (rsta) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // Address hold mux: load the granted port's address, otherwise keep the
    // previous one so the ROM address bus does not toggle while idle.
    always_comb begin
        rom_addra_d = rom_addra_q;
        if (gnt0) begin
            rom_addra_d = addr0;
        end else if (gnt1) begin
            rom_addra_d = addr1;
        end
    end

    // ROM address register.
    always_ff @(posedge clka) begin
        if (rsta) begin
            rom_addra_q <= '0;
        end else begin
            rom_addra_q <= rom_addra_d;
        end
    end

    assign rom_addra = rom_addra_q;

    // Tag for this cycle's slot: a grant records its port, no grant records a bubble.
    always_comb begin
        push_tag       = TAG_IDLE;
        push_tag.valid = gnt0 | gnt1;
        push_tag.port  = gnt1 ? PORT1 : PORT0;
    end

    rom_arb_pipe #(
        .DEPTH (ROM_LAT)
    ) u_pipe (
        .clka (clka),
        .rsta (rsta),
        .push (push_tag),
        .tail (tail_tag)
    );

    // Response steering: the tail tag says whose word is on rom_doa this cycle.
    // Data is broadcast to both ports; only the matching rvalid qualifies it.
    assign rvalid0 = tail_tag.valid && (tail_tag.port == PORT0);
    assign rvalid1 = tail_tag.valid && (tail_tag.port == PORT1);
    assign rdata0  = rom_doa;
    assign rdata1  = rom_doa;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter. Two instances share one stimulus stream:
// ROM_LAT=1 and ROM_LAT=2, each with its own behavioural ROM. Expected values come
// from a scoreboard of issued reads with their due cycle.
// Honours ROM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int AW = ROM_ADDR_W;
    localparam int DW = ROM_DATA_W;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        int            due;
    } resp_t;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic          rsta;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;

    logic          gnt0_a, gnt1_a, rv0_a, rv1_a;
    logic [DW-1:0] rd0_a, rd1_a, doa_a;
    logic [AW-1:0] ra_a;
    logic          gnt0_b, gnt1_b, rv0_b, rv1_b;
    logic [DW-1:0] rd0_b, rd1_b, doa_b;
    logic [AW-1:0] ra_b;

    int tests = 0;
    int fails = 0;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {3'b101, a, 16'h0000} ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // Behavioural ROMs: latency 1 reads straight from the held address,
    // latency 2 adds one output register.
    assign doa_a = rom_word(ra_a);
    always @(posedge clka) doa_b <= rom_word(ra_b);

    rom_arbiter #(.ROM_LAT(1), .ADDR_W(AW), .DATA_W(DW)) dut_l1 (
        .clka(clka), .rsta(rsta),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0_a), .gnt1(gnt1_a),
        .rvalid0(rv0_a), .rdata0(rd0_a), .rvalid1(rv1_a), .rdata1(rd1_a),
        .rom_addra(ra_a), .rom_doa(doa_a)
    );

    rom_arbiter #(.ROM_LAT(2), .ADDR_W(AW), .DATA_W(DW)) dut_l2 (
        .clka(clka), .rsta(rsta),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0_b), .gnt1(gnt1_b),
        .rvalid0(rv0_b), .rdata0(rd0_b), .rvalid1(rv1_b), .rdata1(rd1_b),
        .rom_addra(ra_b), .rom_doa(doa_b)
    );

    // Reference model state
    int            edge_n    = 0;
    int            last_port = 1;
    logic [AW-1:0] exp_addr  = '0;
    resp_t         q_a[$];
    resp_t         q_b[$];
    logic          exp_g0, exp_g1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_resp(input string tag, input logic rv0, input logic rv1,
                              input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                              input logic ev0, input logic ev1, input logic [DW-1:0] ed);
        check({"rvalid0_", tag}, 32'(rv0), 32'(ev0));
        check({"rvalid1_", tag}, 32'(rv1), 32'(ev1));
        if (ev0) check({"rdata0_", tag}, rd0, ed);
        if (ev1) check({"rdata1_", tag}, rd1, ed);
    endtask

    task automatic drive(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1, input logic rst);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; rsta = rst;
    endtask

    // One clock cycle: check grants, advance the model at the edge, check outputs.
    task automatic step();
        logic          g0, g1, ev0, ev1;
        logic [DW-1:0] ed;
        resp_t         r;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rsta) begin
            if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                g0 = 1'b1;
`else
                g0 = (last_port != 0);
                g1 = (last_port == 0);
`endif
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
        exp_g0 = g0;
        exp_g1 = g1;
        check("gnt0_l1", 32'(gnt0_a), 32'(g0));
        check("gnt1_l1", 32'(gnt1_a), 32'(g1));
        check("gnt0_l2", 32'(gnt0_b), 32'(g0));
        check("gnt1_l2", 32'(gnt1_b), 32'(g1));

        @(posedge clka);
        edge_n++;
        if (rsta) begin
            q_a.delete();
            q_b.delete();
            last_port = 1;
            exp_addr  = '0;
        end else if (g0 || g1) begin
            r.port = g1;
            r.addr = g1 ? addr1 : addr0;
            r.due  = edge_n;
            q_a.push_back(r);
            r.due  = edge_n + 1;
            q_b.push_back(r);
            last_port = g1 ? 1 : 0;
            exp_addr  = r.addr;
        end

        #1;
        check("rom_addra_l1", 32'(ra_a), 32'(exp_addr));
        check("rom_addra_l2", 32'(ra_b), 32'(exp_addr));

        ev0 = 1'b0; ev1 = 1'b0; ed = '0;
        if (q_a.size() > 0 && q_a[0].due == edge_n) begin
            r = q_a.pop_front();
            ev0 = !r.port; ev1 = r.port; ed = rom_word(r.addr);
        end
        check_resp("l1", rv0_a, rv1_a, rd0_a, rd1_a, ev0, ev1, ed);

        ev0 = 1'b0; ev1 = 1'b0; ed = '0;
        if (q_b.size() > 0 && q_b[0].due == edge_n) begin
            r = q_b.pop_front();
            ev0 = !r.port; ev1 = r.port; ed = rom_word(r.addr);
        end
        check_resp("l2", rv0_b, rv1_b, rd0_b, rd1_b, ev0, ev1, ed);
    endtask

    initial begin
        // Reset with requests present: grants must stay low.
        drive(1'b1, 13'h0000, 1'b1, 13'h0000, 1'b1);
        repeat (2) step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        step();

        // Single read on port 0.
        drive(1'b1, 13'h0010, 1'b0, 13'h0000, 1'b0);
        step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (3) step();

        // Conflict with the address extremes: grants alternate.
        drive(1'b1, 13'h0001, 1'b1, 13'h1FFF, 1'b0);
        repeat (4) step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (3) step();

        // Back-to-back reads on port 1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 13'h0000, 1'b1, 13'(13'h0100 + i), 1'b0);
            step();
        end
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (3) step();

        // Idle hold of the ROM address.
        drive(1'b1, 13'h0AAA, 1'b0, 13'h0000, 1'b0);
        step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (5) step();

        // Reset one edge after a grant, then a conflict.
        drive(1'b1, 13'h0123, 1'b0, 13'h0000, 1'b0);
        step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b1);
        step();
        drive(1'b1, 13'h0001, 1'b1, 13'h1FFF, 1'b0);
        repeat (2) step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (3) step();

        // Sustained conflict for six cycles.
        drive(1'b1, 13'h0055, 1'b1, 13'h0066, 1'b0);
        repeat (6) step();
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (3) step();

        // Random traffic obeying the hold-until-granted handshake, with rare resets.
        for (int n = 0; n < 400; n++) begin
            if (!req0 || exp_g0) begin
                req0  = ($urandom_range(0, 3) != 0);
                addr0 = AW'($urandom);
            end
            if (!req1 || exp_g1) begin
                req1  = ($urandom_range(0, 2) != 0);
                addr1 = AW'($urandom);
            end
            rsta = ($urandom_range(0, 49) == 0);
            step();
        end
        drive(1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
